// File: rtl/can_tx_if.sv
// can_tx_if: frame request, status and bus-line signals for the CAN 2.0A transmitter.
// master = frame requester / bus side, slave = the transmitter itself.
`timescale 1ns/1ps
interface can_tx_if;
   logic        Start;
   logic [10:0] Id;
   logic [3:0]  Dlc;
   logic [63:0] Data;
   logic        Bus_Input;
   logic        Tx_Bit;
   logic        Busy;
   logic        Done;
   logic        Ack_Error;
   logic        Arb_Lost;

   modport master (
      output Start, Id, Dlc, Data, Bus_Input,
      input  Tx_Bit, Busy, Done, Ack_Error, Arb_Lost
   );

   modport slave (
      input  Start, Id, Dlc, Data, Bus_Input,
      output Tx_Bit, Busy, Done, Ack_Error, Arb_Lost
   );
endinterface

// File: rtl/can_tx.sv
// can_tx: CAN 2.0A standard data-frame transmitter.
// Serialises SOF..IFS at CLKS_PER_BIT clocks per bit with CRC-15 and bit stuffing,
// samples the bus at SAMPLE_CLK for the ACK slot.
// Optional macro CAN_TX_ARB_EN: arbitration-loss detection during ID/RTR.
`timescale 1ns/1ps
module can_tx #(
   parameter int CLKS_PER_BIT = 10,
   parameter int SAMPLE_CLK   = 7
) (
   input  logic    Clock_TB,
   input  logic    Reset_N,
   can_tx_if.slave bus
);

   // state      | meaning
   // -----------+---------------------------------------------
   // S_IDLE     | waiting for Start, line recessive
   // S_SOF      | start of frame, dominant
   // S_ID       | 11 identifier bits, MSB first
   // S_RTR      | remote request bit, dominant (data frame)
   // S_IDE      | identifier extension bit, dominant
   // S_R0       | reserved bit, dominant
   // S_DLC      | 4 data length code bits
   // S_DATA     | 8*min(Dlc,8) payload bits
   // S_CRC      | 15 CRC bits, MSB first (last stuffed field)
   // S_CRC_DEL  | CRC delimiter, recessive
   // S_ACK_SLOT | ACK slot, recessive driven, bus sampled
   // S_ACK_DEL  | ACK delimiter, recessive
   // S_EOF      | 7 end-of-frame bits, recessive
   // S_IFS      | 3 intermission bits, Done at the end

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SOF,
      S_ID,
      S_RTR,
      S_IDE,
      S_R0,
      S_DLC,
      S_DATA,
      S_CRC,
      S_CRC_DEL,
      S_ACK_SLOT,
      S_ACK_DEL,
      S_EOF,
      S_IFS
   } state_t;

   state_t         state;
   state_t         state_nxt;
   state_t         adv_state;
   logic [6:0]     bit_cnt;
   logic [6:0]     bit_cnt_nxt;
   logic [6:0]     adv_cnt;
   logic           adv_val;
   logic [CW-1:0]  clk_cnt;
   logic [CW-1:0]  clk_cnt_nxt;
   logic           bit_end;

   logic           tx_bit;
   logic           tx_nxt;
   logic           stuff_bit;
   logic           stuff_nxt;
   logic [2:0]     run_len;
   logic [2:0]     run_nxt;
   logic [14:0]    crc;
   logic [14:0]    crc_nxt;
   logic           busy;
   logic           busy_nxt;
   logic           done;
   logic           done_nxt;
   logic           load;
   logic           ack_err;
   logic           arb_hit;

   logic [10:0]    id_r;
   logic [3:0]     dlc_r;
   logic [63:0]    data_r;
   logic [3:0]     n_bytes;
   logic [6:0]     last_data;
   logic           in_stuff_zone;

   function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
      logic        fb;
      logic [14:0] r;
      fb = b ^ c[14];
      r  = {c[13:0], 1'b0};
      if (fb) begin
         r = r ^ 15'h4599;
      end
      return r;
   endfunction

   assign bit_end       = (clk_cnt == CW'(CLKS_PER_BIT - 1));
   assign n_bytes       = (dlc_r > 4'd8) ? 4'd8 : dlc_r;
   assign last_data     = {n_bytes, 3'b000} - 7'd1;
   assign in_stuff_zone = (state inside {S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC});

`ifdef CAN_TX_ARB_EN
   logic arb_lost;
   assign arb_hit = arb_lost && !(state inside {S_IDLE, S_IFS});
`else
   assign arb_hit = 1'b0;
`endif

   // Field position that follows the current one (ignoring stuff bits).
   always_comb begin
      adv_state = state;
      adv_cnt   = bit_cnt + 7'd1;
      case (state)
         S_SOF: begin
            adv_state = S_ID;
            adv_cnt   = 7'd0;
         end
         S_ID: begin
            if (bit_cnt == 7'd10) begin
               adv_state = S_RTR;
               adv_cnt   = 7'd0;
            end
         end
         S_RTR: begin
            adv_state = S_IDE;
            adv_cnt   = 7'd0;
         end
         S_IDE: begin
            adv_state = S_R0;
            adv_cnt   = 7'd0;
         end
         S_R0: begin
            adv_state = S_DLC;
            adv_cnt   = 7'd0;
         end
         S_DLC: begin
            if (bit_cnt == 7'd3) begin
               adv_state = (n_bytes == 4'd0) ? S_CRC : S_DATA;
               adv_cnt   = 7'd0;
            end
         end
         S_DATA: begin
            if (bit_cnt == last_data) begin
               adv_state = S_CRC;
               adv_cnt   = 7'd0;
            end
         end
         S_CRC: begin
            if (bit_cnt == 7'd14) begin
               adv_state = S_CRC_DEL;
               adv_cnt   = 7'd0;
            end
         end
         S_CRC_DEL: begin
            adv_state = S_ACK_SLOT;
            adv_cnt   = 7'd0;
         end
         S_ACK_SLOT: begin
            adv_state = S_ACK_DEL;
            adv_cnt   = 7'd0;
         end
         S_ACK_DEL: begin
            adv_state = S_EOF;
            adv_cnt   = 7'd0;
         end
         S_EOF: begin
            if (bit_cnt == 7'd6) begin
               adv_state = S_IFS;
               adv_cnt   = 7'd0;
            end
         end
         S_IFS: begin
            if (bit_cnt == 7'd2) begin
               adv_state = S_IDLE;
               adv_cnt   = 7'd0;
            end
         end
         default: begin
            adv_state = S_IDLE;
            adv_cnt   = 7'd0;
         end
      endcase
   end

   // Line level of the next field position.
   always_comb begin
      adv_val = 1'b1;
      case (adv_state)
         S_SOF, S_RTR, S_IDE, S_R0: adv_val = 1'b0;
         S_ID:    adv_val = id_r[4'd10 - adv_cnt[3:0]];
         S_DLC:   adv_val = dlc_r[2'd3 - adv_cnt[1:0]];
         S_DATA:  adv_val = data_r[6'd63 - adv_cnt[5:0]];
         S_CRC:   adv_val = crc[4'd14 - adv_cnt[3:0]];
         default: adv_val = 1'b1;
      endcase
   end

   // Next-state and bit-boundary decisions: start, arbitration abort, stuff insert, advance.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      tx_nxt      = tx_bit;
      stuff_nxt   = stuff_bit;
      run_nxt     = run_len;
      crc_nxt     = crc;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      load        = 1'b0;
      clk_cnt_nxt = bit_end ? '0 : clk_cnt + CW'(1);
      if (state == S_IDLE) begin
         clk_cnt_nxt = '0;
         tx_nxt      = 1'b1;
         stuff_nxt   = 1'b0;
         if (bus.Start) begin
            load        = 1'b1;
            state_nxt   = S_SOF;
            bit_cnt_nxt = 7'd0;
            tx_nxt      = 1'b0;
            run_nxt     = 3'd1;
            // Initial CRC is 0 and SOF is dominant, so SOF leaves it at 0.
            crc_nxt     = 15'd0;
            busy_nxt    = 1'b1;
         end
      end else if (bit_end) begin
         if (arb_hit) begin
            state_nxt   = S_IFS;
            bit_cnt_nxt = 7'd0;
            tx_nxt      = 1'b1;
            stuff_nxt   = 1'b0;
         end else if (in_stuff_zone && run_len == 3'd5) begin
            tx_nxt    = ~tx_bit;
            stuff_nxt = 1'b1;
            run_nxt   = 3'd1;
         end else if (adv_state == S_IDLE) begin
            state_nxt   = S_IDLE;
            bit_cnt_nxt = 7'd0;
            tx_nxt      = 1'b1;
            stuff_nxt   = 1'b0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b1;
         end else begin
            state_nxt   = adv_state;
            bit_cnt_nxt = adv_cnt;
            tx_nxt      = adv_val;
            stuff_nxt   = 1'b0;
            run_nxt     = (adv_val == tx_bit) ? run_len + 3'd1 : 3'd1;
            if (adv_state inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA}) begin
               crc_nxt = crc_step(crc, adv_val);
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge Clock_TB) begin
      if (!Reset_N) begin
         state   <= S_IDLE;
         bit_cnt <= 7'd0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   // Bit timer, line driver, stuffing/CRC state, frame latches and status flags.
   always_ff @(posedge Clock_TB) begin
      if (!Reset_N) begin
         clk_cnt   <= '0;
         tx_bit    <= 1'b1;
         stuff_bit <= 1'b0;
         run_len   <= 3'd0;
         crc       <= 15'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ack_err   <= 1'b0;
         id_r      <= 11'd0;
         dlc_r     <= 4'd0;
         data_r    <= 64'd0;
      end else begin
         clk_cnt   <= clk_cnt_nxt;
         tx_bit    <= tx_nxt;
         stuff_bit <= stuff_nxt;
         run_len   <= run_nxt;
         crc       <= crc_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         if (load) begin
            id_r    <= bus.Id;
            dlc_r   <= bus.Dlc;
            data_r  <= bus.Data;
            ack_err <= 1'b0;
         end else if (state == S_ACK_SLOT && clk_cnt == CW'(SAMPLE_CLK) && bus.Bus_Input) begin
            ack_err <= 1'b1;
         end
      end
   end

`ifdef CAN_TX_ARB_EN
   // Arbitration loss: we send recessive but the bus reads dominant during ID/RTR.
   always_ff @(posedge Clock_TB) begin
      if (!Reset_N) begin
         arb_lost <= 1'b0;
      end else if (load) begin
         arb_lost <= 1'b0;
      end else if ((state == S_ID || state == S_RTR) && !stuff_bit &&
                   clk_cnt == CW'(SAMPLE_CLK) && tx_bit && !bus.Bus_Input) begin
         arb_lost <= 1'b1;
      end
   end
   assign bus.Arb_Lost = arb_lost;
`else
   assign bus.Arb_Lost = 1'b0;
`endif

   assign bus.Tx_Bit    = tx_bit;
   assign bus.Busy      = busy;
   assign bus.Done      = done;
   assign bus.Ack_Error = ack_err;

endmodule

// File: tb/tb_can_tx.sv
// tb_can_tx: directed bench for can_tx with a bitwise frame/CRC/stuffing model
// and a destuffing receiver that recovers the transmitted fields.
`timescale 1ns/1ps
module tb_can_tx;
   logic Clock_TB = 1'b0;
   logic Reset_N;
   logic force_dom;
   int   n_total = 0;
   int   n_bad   = 0;

   can_tx_if bus_if();

   can_tx #(.CLKS_PER_BIT(10), .SAMPLE_CLK(7)) dut (
      .Clock_TB (Clock_TB),
      .Reset_N  (Reset_N),
      .bus      (bus_if.slave)
   );

   always #50 Clock_TB = ~Clock_TB;

   // Wired-AND bus: our own drive, pulled dominant when the bench forces it.
   assign bus_if.Bus_Input = bus_if.Tx_Bit & ~force_dom;

   logic        cap_q[$];
   logic        exp_q[$];
   logic        ub[$];
   int          done_cyc;
   logic [14:0] exp_crc;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic build_model(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
      int          nb;
      int          run;
      logic        last;
      logic        fb;
      logic [14:0] c;
      nb = (dlc > 4'd8) ? 8 : int'(dlc);
      ub.delete();
      exp_q.delete();
      ub.push_back(1'b0);
      for (int i = 10; i >= 0; i--) ub.push_back(id[i]);
      repeat (3) ub.push_back(1'b0);
      for (int i = 3; i >= 0; i--) ub.push_back(dlc[i]);
      for (int i = 63; i >= 64 - 8 * nb; i--) ub.push_back(data[i]);
      c = 15'd0;
      foreach (ub[k]) begin
         fb = ub[k] ^ c[14];
         c  = {c[13:0], 1'b0};
         if (fb) c = c ^ 15'h4599;
      end
      exp_crc = c;
      for (int i = 14; i >= 0; i--) ub.push_back(c[i]);
      run  = 0;
      last = 1'b0;
      foreach (ub[k]) begin
         exp_q.push_back(ub[k]);
         if (run > 0 && ub[k] == last) run++;
         else run = 1;
         last = ub[k];
         if (run == 5) begin
            exp_q.push_back(~last);
            last = ~last;
            run  = 1;
         end
      end
      repeat (13) exp_q.push_back(1'b1);
   endtask

   task automatic start_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                              input bit hold_start);
      @(negedge Clock_TB);
      bus_if.Start = 1'b1;
      bus_if.Id    = id;
      bus_if.Dlc   = dlc;
      bus_if.Data  = data;
      @(posedge Clock_TB);
      #1;
      if (hold_start) begin
         bus_if.Id   = ~id;
         bus_if.Dlc  = ~dlc;
         bus_if.Data = ~data;
      end else begin
         bus_if.Start = 1'b0;
      end
   endtask

   task automatic capture(input int force_idx, input int budget, input bit hold_start);
      int cyc;
      cyc      = 0;
      done_cyc = -1;
      cap_q.delete();
      while (done_cyc < 0 && cyc < budget) begin
         force_dom = (cyc / 10 == force_idx);
         if (hold_start && cyc == 3) bus_if.Start = 1'b0;
         if (cyc % 10 == 5) cap_q.push_back(bus_if.Tx_Bit);
         @(posedge Clock_TB);
         #1;
         cyc++;
         if (bus_if.Done) done_cyc = cyc;
      end
      force_dom    = 1'b0;
      bus_if.Start = 1'b0;
   endtask

   task automatic decode_frame(output logic [10:0] d_id, output logic [3:0] d_dlc,
                               output logic [63:0] d_data, output logic [14:0] d_crc,
                               output logic serr, output logic d_del);
      logic ubd[$];
      int   i, run, need, nb;
      logic last, b;
      ubd.delete();
      i = 0; run = 0; need = 34; nb = 0; last = 1'b0;
      serr = 1'b0; d_id = '0; d_dlc = '0; d_data = '0; d_crc = '0; d_del = 1'b0;
      while (ubd.size() < need && i < cap_q.size()) begin
         b = cap_q[i];
         i++;
         if (run == 5) begin
            if (b == last) serr = 1'b1;
            last = b;
            run  = 1;
            continue;
         end
         if (run > 0 && b == last) run++;
         else run = 1;
         last = b;
         ubd.push_back(b);
         if (ubd.size() == 19) begin
            for (int k = 0; k < 4; k++) d_dlc[3-k] = ubd[15+k];
            nb   = (d_dlc > 4'd8) ? 8 : int'(d_dlc);
            need = 34 + 8 * nb;
         end
      end
      if (run == 5 && i < cap_q.size()) begin
         if (cap_q[i] == last) serr = 1'b1;
         i++;
      end
      if (i < cap_q.size()) d_del = cap_q[i];
      if (ubd.size() == need) begin
         for (int k = 0; k < 11; k++) d_id[10-k] = ubd[1+k];
         for (int k = 0; k < 8 * nb; k++) d_data[63-k] = ubd[19+k];
         for (int k = 0; k < 15; k++) d_crc[14-k] = ubd[19+8*nb+k];
      end else begin
         serr = 1'b1;
      end
   endtask

   task automatic run_full(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                           input bit ack_dom, input bit hold_start);
      int          diffs;
      int          ack_idx;
      logic [10:0] d_id;
      logic [3:0]  d_dlc;
      logic [63:0] d_data;
      logic [14:0] d_crc;
      logic        serr, d_del;
      build_model(id, dlc, data);
      ack_idx = ack_dom ? (exp_q.size() - 13 + 1) : -1;
      start_frame(id, dlc, data, hold_start);
      check_val("busy_on", 64'(bus_if.Busy), 64'd1);
      check_val("sof", 64'(bus_if.Tx_Bit), 64'd0);
      check_val("ack_clr", 64'(bus_if.Ack_Error), 64'd0);
      check_val("arb_clr", 64'(bus_if.Arb_Lost), 64'd0);
      capture(ack_idx, exp_q.size() * 10 + 100, hold_start);
      check_val("done_seen", 64'(done_cyc >= 0), 64'd1);
      check_val("done_cycle", 64'(done_cyc), 64'(exp_q.size() * 10));
      check_val("busy_off", 64'(bus_if.Busy), 64'd0);
      check_val("frame_len", 64'(cap_q.size()), 64'(exp_q.size()));
      diffs = 0;
      for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++)
         if (cap_q[k] !== exp_q[k]) diffs++;
      check_val("stream_bits", 64'(diffs), 64'd0);
      check_val("ack_err", 64'(bus_if.Ack_Error), 64'(!ack_dom));
      check_val("arb_none", 64'(bus_if.Arb_Lost), 64'd0);
      decode_frame(d_id, d_dlc, d_data, d_crc, serr, d_del);
      check_val("rx_stuff_err", 64'(serr), 64'd0);
      check_val("rx_id", 64'(d_id), 64'(id));
      check_val("rx_dlc", 64'(d_dlc), 64'(dlc));
      check_val("rx_data", d_data, data);
      check_val("rx_crc", 64'(d_crc), 64'(exp_crc));
      check_val("rx_crc_del", 64'(d_del), 64'd1);
      @(posedge Clock_TB);
      #1;
      check_val("done_pulse", 64'(bus_if.Done), 64'd0);
      repeat (2) @(posedge Clock_TB);
   endtask

   initial begin
      int   n_done;
      logic [7:0] arb_bits;
      Reset_N      = 1'b0;
      force_dom    = 1'b0;
      bus_if.Start = 1'b0;
      bus_if.Id    = '0;
      bus_if.Dlc   = '0;
      bus_if.Data  = '0;
      repeat (3) @(posedge Clock_TB);
      #1;
      check_val("rst_tx", 64'(bus_if.Tx_Bit), 64'd1);
      check_val("rst_busy", 64'(bus_if.Busy), 64'd0);
      check_val("rst_done", 64'(bus_if.Done), 64'd0);
      check_val("rst_ack", 64'(bus_if.Ack_Error), 64'd0);
      check_val("rst_arb", 64'(bus_if.Arb_Lost), 64'd0);
      @(negedge Clock_TB);
      Reset_N = 1'b1;

      // Id 0x123, 2 bytes, ACK given.
      run_full(11'h123, 4'd2, 64'hA55A_0000_0000_0000, 1'b1, 1'b0);

      // All-dominant frame: 34 zeros through CRC, stuffed to 40 bits, 53 bits total.
      run_full(11'h000, 4'd0, 64'd0, 1'b1, 1'b0);
      check_val("len_id0", 64'(cap_q.size()), 64'd53);
      check_val("crc_id0", 64'(exp_crc), 64'd0);

      // Same frame, nobody acknowledges.
      run_full(11'h000, 4'd0, 64'd0, 1'b0, 1'b0);

      // Dlc 12 sends 8 bytes; Start held high (with changed fields) while busy.
      run_full(11'h000, 4'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

      // Reset mid-DATA (bit 22 of a 0x555/Dlc=1 frame).
      start_frame(11'h555, 4'd1, 64'h3C00_0000_0000_0000, 1'b0);
      repeat (222) @(posedge Clock_TB);
      @(negedge Clock_TB);
      Reset_N = 1'b0;
      @(posedge Clock_TB);
      #1;
      check_val("mid_rst_tx", 64'(bus_if.Tx_Bit), 64'd1);
      check_val("mid_rst_busy", 64'(bus_if.Busy), 64'd0);
      check_val("mid_rst_done", 64'(bus_if.Done), 64'd0);
      @(negedge Clock_TB);
      Reset_N = 1'b1;
      n_done = 0;
      repeat (400) begin
         @(posedge Clock_TB);
         #1;
         if (bus_if.Done) n_done++;
      end
      check_val("mid_rst_no_done", 64'(n_done), 64'd0);
      check_val("mid_rst_idle_tx", 64'(bus_if.Tx_Bit), 64'd1);

`ifdef CAN_TX_ARB_EN
      // Id 0x7FF, bus dominant during ID bit 3 (line bit 4): abort after bit 4, then 3 IFS bits.
      start_frame(11'h7FF, 4'd1, 64'd0, 1'b0);
      capture(4, 300, 1'b0);
      check_val("arb_done_cycle", 64'(done_cyc), 64'd80);
      check_val("arb_lost", 64'(bus_if.Arb_Lost), 64'd1);
      check_val("arb_len", 64'(cap_q.size()), 64'd8);
      arb_bits = 8'h00;
      for (int k = 0; k < 8 && k < cap_q.size(); k++) arb_bits[7-k] = cap_q[k];
      check_val("arb_stream", 64'(arb_bits), 64'h7F);
      repeat (2) @(posedge Clock_TB);
`else
      arb_bits = 8'h00;
`endif

      // Full frame after the aborted one.
      run_full(11'h555, 4'd1, 64'h3C00_0000_0000_0000, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #20_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
